// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALUOp and func10 codes,
// forwarding-source select, multiplier FSM states and the hazard helper.
package ex_pkg;

  localparam logic [2:0] ALUOP_R  = 3'b000;
  localparam logic [2:0] ALUOP_I  = 3'b001;
  localparam logic [2:0] ALUOP_LS = 3'b010;

  // func10 = {funct7, funct3}
  localparam logic [9:0] F10_ADD  = 10'b0000000_000;
  localparam logic [9:0] F10_SUB  = 10'b0100000_000;
  localparam logic [9:0] F10_MUL  = 10'b0000001_000;
  localparam logic [9:0] F10_AND  = 10'b0000000_111;
  localparam logic [9:0] F10_XOR  = 10'b0000000_100;
  localparam logic [9:0] F10_SLL  = 10'b0000000_001;
  localparam logic [9:0] F10_SRAI = 10'b0100000_101;

  typedef enum logic [1:0] {
    FWD_IDEX  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  // Pick the freshest source for one operand; the younger EX/MEM result
  // beats MEM/WB, and x0 is never forwarded.
  function automatic fwd_sel_e fwd_select(
    input logic       exmem_we,
    input logic [4:0] exmem_rd,
    input logic       memwb_we,
    input logic [4:0] memwb_rd,
    input logic [4:0] rs
  );
    if (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == rs)) begin
      return FWD_EXMEM;
    end else if (memwb_we && (memwb_rd != 5'd0) && (memwb_rd == rs)) begin
      return FWD_MEMWB;
    end else begin
      return FWD_IDEX;
    end
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// ID/EX inputs, forwarding sources and EX/MEM outputs of the execute stage.
interface ex_mem_stage_if #(
  parameter int XLEN = 32
);
  logic            mem_stall_i;
  logic            regwrite_i;
  logic            memtoreg_i;
  logic            memread_i;
  logic            memwrite_i;
  logic [2:0]      aluop_i;
  logic            alusrc_i;
  logic [XLEN-1:0] rs1data_i;
  logic [XLEN-1:0] rs2data_i;
  logic [XLEN-1:0] imm_i;
  logic [9:0]      func10_i;
  logic [4:0]      rd_i;
  logic [4:0]      rs1_i;
  logic [4:0]      rs2_i;
  logic            memwb_regwrite_i;
  logic [4:0]      memwb_rd_i;
  logic [XLEN-1:0] memwb_wdata_i;
  logic            stall_o;
  logic            exmem_regwrite_o;
  logic            exmem_memtoreg_o;
  logic            exmem_memread_o;
  logic            exmem_memwrite_o;
  logic [XLEN-1:0] exmem_result_o;
  logic [XLEN-1:0] exmem_wdata_o;
  logic [4:0]      exmem_rd_o;

  // Pipeline side: drives the ID/EX and MEM/WB values, observes EX/MEM.
  modport master (
    output mem_stall_i, regwrite_i, memtoreg_i, memread_i, memwrite_i,
           aluop_i, alusrc_i, rs1data_i, rs2data_i, imm_i, func10_i,
           rd_i, rs1_i, rs2_i, memwb_regwrite_i, memwb_rd_i, memwb_wdata_i,
    input  stall_o, exmem_regwrite_o, exmem_memtoreg_o, exmem_memread_o,
           exmem_memwrite_o, exmem_result_o, exmem_wdata_o, exmem_rd_o
  );

  // Execute stage side.
  modport slave (
    input  mem_stall_i, regwrite_i, memtoreg_i, memread_i, memwrite_i,
           aluop_i, alusrc_i, rs1data_i, rs2data_i, imm_i, func10_i,
           rd_i, rs1_i, rs2_i, memwb_regwrite_i, memwb_rd_i, memwb_wdata_i,
    output stall_o, exmem_regwrite_o, exmem_memtoreg_o, exmem_memread_o,
           exmem_memwrite_o, exmem_result_o, exmem_wdata_o, exmem_rd_o
  );
endinterface

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier: latches operands on start, retires
// MUL_STEP multiplier bits per cycle, reports DONE for one cycle.
module ex_mul_iter
  import ex_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            hold_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] product_o
);

  localparam int N     = XLEN / MUL_STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  mul_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic [XLEN-1:0]  acc_q;
  logic [XLEN-1:0]  pp_terms [MUL_STEP];
  logic [XLEN-1:0]  pp_sum;

  // One shifted copy of the multiplicand per multiplier bit in this step.
  for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_pp
    assign pp_terms[gi] = b_q[gi] ? (a_q << gi) : '0;
  end

  // Sum the partial products of the current step.
  always_comb begin
    pp_sum = '0;
    for (int k = 0; k < MUL_STEP; k++) begin
      pp_sum = pp_sum + pp_terms[k];
    end
  end

  // Multiplier FSM and datapath; everything freezes while hold_i is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else if (!hold_i) begin
      case (state_q)
        MUL_IDLE: begin
          if (start_i) begin
            a_q     <= op_a_i;
            b_q     <= op_b_i;
            acc_q   <= '0;
            cnt_q   <= CNT_W'(N - 1);
            state_q <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          acc_q <= acc_q + pp_sum;
          a_q   <= a_q << MUL_STEP;
          b_q   <= b_q >> MUL_STEP;
          if (cnt_q == '0) begin
            state_q <= MUL_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        MUL_DONE: state_q <= MUL_IDLE;
        default:  state_q <= MUL_IDLE;
      endcase
    end
  end

  assign busy_o    = (state_q == MUL_BUSY);
  assign done_o    = (state_q == MUL_DONE);
  assign product_o = acc_q;

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM pipeline register: operand forwarding, ALU,
// iterative MUL with upstream stall, and bubble insertion while stalled.
module ex_mem_stage
  import ex_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic         clk,
  input  logic         reset,
  ex_mem_stage_if.slave ex_bus
);

  fwd_sel_e        sel_a;
  fwd_sel_e        sel_b;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_result;
  logic            is_mul;
  logic            mul_start;
  logic            mul_busy;
  logic            mul_done;
  logic [XLEN-1:0] mul_product;
  logic            stall;

  logic            regwrite_q;
  logic            memtoreg_q;
  logic            memread_q;
  logic            memwrite_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] wdata_q;
  logic [4:0]      rd_q;

  assign sel_a = fwd_select(regwrite_q, rd_q, ex_bus.memwb_regwrite_i,
                            ex_bus.memwb_rd_i, ex_bus.rs1_i);
  assign sel_b = fwd_select(regwrite_q, rd_q, ex_bus.memwb_regwrite_i,
                            ex_bus.memwb_rd_i, ex_bus.rs2_i);

  // Forwarding muxes for both register operands.
  always_comb begin
    case (sel_a)
      FWD_EXMEM: fwd_rs1 = result_q;
      FWD_MEMWB: fwd_rs1 = ex_bus.memwb_wdata_i;
      default:   fwd_rs1 = ex_bus.rs1data_i;
    endcase
    case (sel_b)
      FWD_EXMEM: fwd_rs2 = result_q;
      FWD_MEMWB: fwd_rs2 = ex_bus.memwb_wdata_i;
      default:   fwd_rs2 = ex_bus.rs2data_i;
    endcase
  end

  assign op_b = ex_bus.alusrc_i ? ex_bus.imm_i : fwd_rs2;

  // Single-cycle ALU; anything not explicitly decoded falls back to ADD.
  always_comb begin
    alu_result = fwd_rs1 + op_b;
    case (ex_bus.aluop_i)
      ALUOP_R: begin
        case (ex_bus.func10_i)
          F10_ADD: alu_result = fwd_rs1 + op_b;
          F10_SUB: alu_result = fwd_rs1 - op_b;
          F10_AND: alu_result = fwd_rs1 & op_b;
          F10_XOR: alu_result = fwd_rs1 ^ op_b;
          F10_SLL: alu_result = fwd_rs1 << op_b[4:0];
          default: alu_result = fwd_rs1 + op_b;
        endcase
      end
      ALUOP_I: begin
        if (ex_bus.func10_i == F10_SRAI) begin
          alu_result = $signed(fwd_rs1) >>> ex_bus.imm_i[4:0];
        end
      end
      ALUOP_LS: alu_result = fwd_rs1 + op_b;
      default:  alu_result = fwd_rs1 + op_b;
    endcase
  end

  assign is_mul    = (ex_bus.aluop_i == ALUOP_R) && (ex_bus.func10_i == F10_MUL);
  assign mul_start = is_mul && !mul_busy && !mul_done;
  assign stall     = mul_start || mul_busy;

  ex_mul_iter #(
    .XLEN     (XLEN),
    .MUL_STEP (MUL_STEP)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start_i   (mul_start),
    .hold_i    (ex_bus.mem_stall_i),
    .op_a_i    (fwd_rs1),
    .op_b_i    (op_b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  // EX/MEM register: bubble while stalling, product on DONE, ALU otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      result_q   <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
    end else if (!ex_bus.mem_stall_i) begin
      if (stall) begin
        regwrite_q <= 1'b0;
        memtoreg_q <= 1'b0;
        memread_q  <= 1'b0;
        memwrite_q <= 1'b0;
        result_q   <= '0;
        wdata_q    <= '0;
        rd_q       <= '0;
      end else begin
        regwrite_q <= ex_bus.regwrite_i;
        memtoreg_q <= ex_bus.memtoreg_i;
        memread_q  <= ex_bus.memread_i;
        memwrite_q <= ex_bus.memwrite_i;
        result_q   <= mul_done ? mul_product : alu_result;
        wdata_q    <= fwd_rs2;
        rd_q       <= ex_bus.rd_i;
      end
    end
  end

  assign ex_bus.stall_o          = stall;
  assign ex_bus.exmem_regwrite_o = regwrite_q;
  assign ex_bus.exmem_memtoreg_o = memtoreg_q;
  assign ex_bus.exmem_memread_o  = memread_q;
  assign ex_bus.exmem_memwrite_o = memwrite_q;
  assign ex_bus.exmem_result_o   = result_q;
  assign ex_bus.exmem_wdata_o    = wdata_q;
  assign ex_bus.exmem_rd_o       = rd_q;

endmodule
